// File: rtl/addsub_chain_8bit.sv
// Multi-byte add/subtract sequencer (LSB byte first) driving an external 8-bit adder.
// It chains the carry or borrow between bytes and registers each byte's result behind a ready/valid handshake.
module addsub_chain_8bit #(
   parameter int unsigned CHAIN_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       in_sub,
   input  logic       in_first,
   input  logic       in_last,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic       add_c_in,
   input  logic [7:0] add_s,
   input  logic       add_c_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_s,
   output logic       out_c,
   output logic       out_last,
   output logic       out_zero,
   output logic       out_ovf,
   output logic       out_err
);

   localparam int unsigned CntW = $clog2(CHAIN_MAX + 1);

   typedef enum logic [0:0] {StIdle, StChain} state_e;

   state_e          r_state, w_state_nxt;
   logic [CntW-1:0] r_count, w_count_nxt, w_count_byte;
   logic            r_carry, r_op;
   logic            r_out_valid, r_out_c, r_out_last, r_out_zero, r_out_ovf, r_out_err;
   logic [7:0]      r_out_s;

   logic w_accept, w_first, w_op, w_restart_err, w_max_err, w_end, w_zero, w_ovf;

   // Outside a chain every byte is a first byte, whatever in_first says.
   assign w_first       = (r_state == StIdle) || in_first;
   assign w_restart_err = (r_state == StChain) && in_first;
   assign w_op          = w_first ? in_sub : r_op;

   assign add_a    = in_a;
   assign add_b    = w_op ? ~in_b : in_b;
   assign add_c_in = w_first ? in_sub : r_carry;

   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   assign w_count_byte = w_first ? CntW'(1) : r_count + CntW'(1);
   assign w_max_err    = (w_count_byte == CntW'(CHAIN_MAX)) && !in_last;
   assign w_end        = in_last || w_max_err;

   assign w_zero = (add_s == 8'h00) && (w_first || r_out_zero);
   assign w_ovf  = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      if (w_accept) begin
         if (w_end) begin
            w_state_nxt = StIdle;
            w_count_nxt = '0;
         end else begin
            w_state_nxt = StChain;
            w_count_nxt = w_count_byte;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_count <= '0;
         r_carry <= 1'b0;
         r_op    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_accept) begin
            r_carry <= add_c_out;
            r_op    <= w_op;
         end
      end
   end

   // Result register: loads on acceptance, otherwise holds (only valid drops on drain).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_s     <= 8'h00;
         r_out_c     <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_zero  <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_out_err   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_s     <= add_s;
         r_out_c     <= add_c_out;
         r_out_last  <= w_end;
         r_out_zero  <= w_zero;
         r_out_ovf   <= w_ovf;
         r_out_err   <= w_restart_err || w_max_err;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_s     = r_out_s;
   assign out_c     = r_out_c;
   assign out_last  = r_out_last;
   assign out_zero  = r_out_zero;
   assign out_ovf   = r_out_ovf;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_addsub_chain_8bit.sv
// Self-checking bench for addsub_chain_8bit: directed vector table, hand sequences for
// backpressure/errors/reset, and random traffic against an arithmetic reference model.
module tb_addsub_chain_8bit;

   localparam int ChainMax = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_sub, in_first, in_last;
   logic [7:0] in_a, in_b, add_a, add_b, add_s;
   logic       add_c_in, add_c_out;
   logic       out_valid, out_ready, out_c, out_last, out_zero, out_ovf, out_err;
   logic [7:0] out_s;
   logic [8:0] w_sum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // The external ripple adder.
   assign w_sum     = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c_in};
   assign add_s     = w_sum[7:0];
   assign add_c_out = w_sum[8];

   addsub_chain_8bit #(.CHAIN_MAX(ChainMax)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_first  (in_first),
      .in_last   (in_last),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c_in  (add_c_in),
      .add_s     (add_s),
      .add_c_out (add_c_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_c     (out_c),
      .out_last  (out_last),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_err   (out_err)
   );

   // Reference model: chain position plus the last presented result.
   logic       m_valid, m_in_chain, m_op, m_carry;
   int         m_count;
   logic [7:0] m_s;
   logic       m_c, m_last, m_zero, m_ovf, m_err;
   logic [7:0] cap_add_b;
   logic       cap_c_in;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] ctl;  // {sub, first, last}
      logic [7:0] eb;
      logic       ecin;
      logic [7:0] es;
      logic [4:0] ef;   // {c, zero, ovf, last, err}
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_in_chain = 1'b0; m_op = 1'b0; m_carry = 1'b0; m_count = 0;
      m_s = 8'h00; m_c = 1'b0; m_last = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
   endtask

   task automatic check_outputs(input string name);
      check(name, {out_valid, out_s, out_c, out_last, out_zero, out_ovf, out_err},
            {m_valid, m_s, m_c, m_last, m_zero, m_ovf, m_err});
   endtask

   // One clock: drive at negedge, check adder drive, model the edge, check registers.
   task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic first, input logic last, input logic rdy);
      logic       f, op, cin, acc, zprev, maxe, exp_rdy;
      logic [7:0] eb, u8;
      int         u, sr, cnt;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_sub = sub; in_first = first; in_last = last;
      out_ready = rdy;
      f       = !m_in_chain || first;
      op      = f ? sub : m_op;
      cin     = f ? sub : m_carry;
      exp_rdy = !m_valid || rdy;
      acc     = v && exp_rdy;
      eb      = op ? ~b : b;
      #1;
      cap_add_b = add_b;
      cap_c_in  = add_c_in;
      check("in_ready", in_ready, exp_rdy);
      check("add_a", add_a, a);
      check("add_b", add_b, eb);
      check("add_c_in", add_c_in, cin);
      @(posedge clk);
      if (acc) begin
         zprev = f ? 1'b1 : m_zero;
         cnt   = f ? 1 : m_count + 1;
         if (op) begin
            u  = int'(a) - int'(b) - (cin ? 0 : 1);
            sr = int'($signed(a)) - int'($signed(b)) - (cin ? 0 : 1);
         end else begin
            u  = int'(a) + int'(b) + int'(cin);
            sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
         end
         u8      = u[7:0];
         maxe    = (cnt == ChainMax) && !last;
         m_s     = u8;
         m_c     = op ? (u >= 0) : (u > 255);
         m_zero  = (u8 == 8'h00) && zprev;
         m_ovf   = (sr > 127) || (sr < -128);
         m_err   = (m_in_chain && first) || maxe;
         m_last  = last || maxe;
         m_carry = m_c;
         m_op    = op;
         m_valid = 1'b1;
         if (last || maxe) begin
            m_in_chain = 1'b0;
            m_count    = 0;
         end else begin
            m_in_chain = 1'b1;
            m_count    = cnt;
         end
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      #1;
      check_outputs("outputs{v,s,c,last,zero,ovf,err}");
   endtask

   initial begin
      vecs[0] = '{8'h03, 8'h05, 3'b011, 8'h05, 1'b0, 8'h08, 5'b00010};
      vecs[1] = '{8'h05, 8'h03, 3'b111, 8'hFC, 1'b1, 8'h02, 5'b10010};
      vecs[2] = '{8'h03, 8'h05, 3'b111, 8'hFA, 1'b1, 8'hFE, 5'b00010};
      vecs[3] = '{8'hFF, 8'h01, 3'b010, 8'h01, 1'b0, 8'h00, 5'b11000};
      vecs[4] = '{8'h01, 8'h00, 3'b001, 8'h00, 1'b1, 8'h02, 5'b00010};
      vecs[5] = '{8'h7F, 8'h01, 3'b011, 8'h01, 1'b0, 8'h80, 5'b00110};
      vecs[6] = '{8'h80, 8'h01, 3'b111, 8'hFE, 1'b1, 8'h7F, 5'b10110};
      vecs[7] = '{8'h00, 8'h01, 3'b110, 8'hFE, 1'b1, 8'hFF, 5'b00000};
      vecs[8] = '{8'h01, 8'h00, 3'b001, 8'hFF, 1'b0, 8'h00, 5'b10010};

      rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_sub = 1'b0;
      in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      model_reset();
      #1;
      check("reset outputs", {out_valid, out_s, out_c, out_last, out_zero, out_ovf, out_err}, 0);
      check("reset in_ready", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         apply(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], 1'b1);
         check($sformatf("vec%0d add_b", i), cap_add_b, vecs[i].eb);
         check($sformatf("vec%0d add_c_in", i), cap_c_in, vecs[i].ecin);
         check($sformatf("vec%0d out_s", i), out_s, vecs[i].es);
         check($sformatf("vec%0d flags", i), {out_c, out_zero, out_ovf, out_last, out_err},
               vecs[i].ef);
      end

      // Backpressure: result held while the sink stalls, queued byte taken on release.
      apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      apply(1'b1, 8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0);
      check("bp first out_s", out_s, 8'h08);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
         check("bp stall in_ready", in_ready, 1'b0);
         check("bp hold out_s", {out_valid, out_s}, 9'h108);
      end
      apply(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
      check("bp release out_s", out_s, 8'h02);

      // Overlong chain, then a mid-chain restart.
      apply(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) apply(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("max err/last", {out_err, out_last}, 2'b11);
      apply(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("after max c_in", cap_c_in, 1'b0);
      check("after max out", {out_s, out_err}, 9'h1FE);
      apply(1'b1, 8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
      check("restart add_b/c_in", {cap_add_b, cap_c_in}, 9'h1F9);
      check("restart out", {out_s, out_err}, 9'h005);
      apply(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("restart tail", {out_s, out_c, out_last, out_err}, 11'h006);

      // Asynchronous reset mid-chain; no stale carry afterwards.
      apply(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("mid reset outputs", {out_valid, out_s, out_c, out_last, out_zero, out_ovf, out_err}, 0);
      check("mid reset in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("post reset c_in", cap_c_in, 1'b0);
      check("post reset out_s", out_s, 8'h01);

      for (int i = 0; i < 2000; i++) begin
         apply($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 1'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) < 7);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addsub_chain_8bit.md
ADDSUB_CHAIN_8BIT -- requirements
Module: addsub_chain_8bit
Sequencer feeding the 8-bit ripple adder (operand select, borrow/carry chaining) and registering its result; multi-byte add/subtract, LSB byte first.

Interface
REQ-001 SHALL have parameter: CHAIN_MAX, default 4, maximum bytes per chain (legal 2..16).
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have: in_valid  in  1  operand byte valid.
REQ-004 SHALL have: in_ready  out  1  operand byte accepted when in_valid&&in_ready at clk edge.
REQ-005 SHALL have: in_a  in  8  minuend/addend byte; in_b  in  8  subtrahend/addend byte.
REQ-006 SHALL have: in_sub  in  1  1=subtract, sampled on first byte of chain only.
REQ-007 SHALL have: in_first  in  1  starts new chain; in_last  in  1  ends chain.
REQ-008 SHALL have: add_a  out  8, add_b  out  8, add_c_in  out  1  drive the 8-bit adder (combinational from in_* and state).
REQ-009 SHALL have: add_s  in  8, add_c_out  in  1  adder sum and carry.
REQ-010 SHALL have: out_valid  out  1; out_ready  in  1  result handshake.
REQ-011 SHALL have: out_s  out  8 byte result; out_c  out  1 carry (subtract: 1=no borrow); out_last  out  1; out_zero  out  1 running all-zero flag; out_ovf  out  1 signed overflow of this byte; out_err  out  1 chain error.

Function
REQ-012 SHALL drive add_a=in_a; add_b=in_b when op=add, ~in_b when op=sub.
REQ-013 SHALL drive add_c_in = op (0 add, 1 sub) for first byte, stored carry for later bytes.
REQ-014 SHALL use op = in_sub on first byte, latched op register for later bytes.
REQ-015 SHALL have in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
REQ-016 SHALL, on acceptance at edge N, present result registered at edge N (out_valid=1 from N): out_s=add_s, out_c=add_c_out, out_last=in_last or forced end.
REQ-017 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid at edge where out_valid&&out_ready and no new acceptance.
REQ-019 SHALL have FSM states IDLE, CHAIN; IDLE->CHAIN on accepted byte with in_last=0; CHAIN->IDLE on accepted byte with in_last=1 or error; any accepted last byte from IDLE stays IDLE.
REQ-020 SHALL in IDLE treat every accepted byte as first regardless of in_first.
REQ-021 SHALL in CHAIN, on accepted byte with in_first=1: restart chain with this byte as first (op=in_sub, c_in=in_sub, count=1), out_err=1 on this byte.
REQ-022 SHALL count bytes per chain; when CHAIN_MAX-th byte accepted with in_last=0: out_err=1, out_last=1, return to IDLE.
REQ-023 SHALL set out_zero = (add_s==0) on first byte, (add_s==0) && previous out_zero thereafter.
REQ-024 SHALL set out_ovf = (add_a[7]==add_b[7]) && (add_s[7]!=add_a[7]); meaningful on last byte.
REQ-025 SHALL store carry = add_c_out on each accepted byte; unchanged otherwise.
REQ-026 SHALL take no action when in_valid=0; in_a/in_b/flags ignored.

Reset
REQ-027 SHALL on rst_n=0 immediately force: state IDLE, count 0, carry 0, op 0, out_valid 0, out_s 0x00, out_c 0, out_last 0, out_zero 0, out_ovf 0, out_err 0.
REQ-028 SHALL abandon any chain in progress on reset; first accepted byte after release is a first byte.
REQ-029 SHALL drive in_ready=1 during and after reset (out_valid=0).

Verification
REQ-030 Single add: a=0x03,b=0x05,first,last,sub=0 -> next edge out_s=0x08,out_c=0,out_zero=0,out_ovf=0,out_last=1.
REQ-031 Subtract: a=0x05,b=0x03,sub=1 -> add_b=0xFC,add_c_in=1; out_s=0x02,out_c=1; a=0x03,b=0x05 -> out_s=0xFE,out_c=0.
REQ-032 16-bit add 0x01FF+0x0001: byte0 FF+01 -> out_s=0x00,out_c=1,out_zero=1; byte1 01+00 -> add_c_in=1,out_s=0x02,out_c=0,out_zero=0,out_last=1.
REQ-033 Backpressure: out_ready=0 after result 0x08 -> in_ready=0, out_* hold 3 cycles; out_ready=1 -> next queued byte accepted same edge.
REQ-034 Errors: CHAIN_MAX=4, five bytes no in_last -> byte4 out_err=1,out_last=1, byte5 is new first (add_c_in=op); in_first mid-chain -> out_err=1, carry restarted.
REQ-035 Reset mid-chain after byte0 of 0x01FF+0x0001 -> outputs zero at once; then 0x01+0x00 single byte -> out_s=0x01 (no stale carry).
